// File: rtl/sfd_detector.sv
// 802.15.4 receive framing: preamble/SFD hunt, PHR length capture, PSDU bit forwarding.
// Optional idle-timeout abort is built when SFD_DET_TIMEOUT_EN is defined.
module sfd_detector #(
  parameter logic [7:0] SFD               = 8'hA7,
  parameter int         PREAMBLE_MIN_BITS = 8,
  parameter int         MAX_LEN           = 127,
  parameter int         TIMEOUT_CYCLES    = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       data_i,
  input  logic       valid_i,
  output logic       data_o,
  output logic       valid_o,
  output logic       frame_active_o,
  output logic       sfd_found_o,
  output logic [6:0] len_o,
  output logic       len_err_o,
  output logic       frame_done_o,
  output logic       abort_o
);

  typedef enum logic [1:0] {HUNT_PRE, HUNT_SFD, LEN, PAYLOAD} state_e;

  localparam logic [7:0]  PRE_MIN = 8'(PREAMBLE_MIN_BITS);
  localparam logic [6:0]  LEN_MAX = 7'(MAX_LEN);
  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYCLES - 1);

  // Elaboration-time parameter sanity check.
  if (SFD[0] != 1'b1 || PREAMBLE_MIN_BITS < 1 || PREAMBLE_MIN_BITS > 255 ||
      MAX_LEN < 1 || MAX_LEN > 127 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("sfd_detector: parameter out of range");
  end

  state_e      state_q, state_d;
  logic [7:0]  zero_cnt_q, zero_cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [9:0]  rem_q, rem_d;
  logic        data_q, data_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        sfd_q, sfd_d;
  logic [6:0]  len_q, len_d;
  logic        len_err_q, len_err_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;
  logic [15:0] idle_q, idle_d;
  logic [7:0]  shifted;

  assign shifted = {data_i, sr_q[7:1]};

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    rem_d      = rem_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    active_d   = active_q;
    sfd_d      = 1'b0;
    len_d      = len_q;
    len_err_d  = 1'b0;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    if (valid_i) begin
      unique case (state_q)
        HUNT_PRE: begin
          if (!data_i) begin
            if (zero_cnt_q != 8'hFF) zero_cnt_d = zero_cnt_q + 8'd1;
          end else if (zero_cnt_q >= PRE_MIN) begin
            sr_d      = 8'h80;
            bit_cnt_d = 3'd1;
            state_d   = HUNT_SFD;
          end else begin
            zero_cnt_d = 8'd0;
          end
        end
        HUNT_SFD: begin
          sr_d      = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shifted == SFD) begin
              sfd_d     = 1'b1;
              active_d  = 1'b1;
              bit_cnt_d = 3'd0;
              state_d   = LEN;
            end else begin
              // No re-scan: buffered bits are discarded with the candidate.
              zero_cnt_d = 8'd0;
              state_d    = HUNT_PRE;
            end
          end
        end
        LEN: begin
          sr_d      = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (shifted[6:0] == 7'd0 || shifted[6:0] > LEN_MAX) begin
              len_err_d  = 1'b1;
              active_d   = 1'b0;
              zero_cnt_d = 8'd0;
              state_d    = HUNT_PRE;
            end else begin
              len_d   = shifted[6:0];
              rem_d   = {shifted[6:0], 3'b000};
              state_d = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          data_d  = data_i;
          valid_d = 1'b1;
          rem_d   = rem_q - 10'd1;
          if (rem_q == 10'd1) begin
            done_d     = 1'b1;
            active_d   = 1'b0;
            zero_cnt_d = 8'd0;
            state_d    = HUNT_PRE;
          end
        end
        default: state_d = HUNT_PRE;
      endcase
    end
`ifdef SFD_DET_TIMEOUT_EN
    else if (state_q != HUNT_PRE && idle_q == TO_LIM) begin
      abort_d    = 1'b1;
      active_d   = 1'b0;
      zero_cnt_d = 8'd0;
      state_d    = HUNT_PRE;
    end
    idle_d = (valid_i || state_d != state_q || state_q == HUNT_PRE) ? 16'd0 : idle_q + 16'd1;
`else
    idle_d = 16'd0;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= HUNT_PRE;
      zero_cnt_q <= 8'd0;
      sr_q       <= 8'd0;
      bit_cnt_q  <= 3'd0;
      rem_q      <= 10'd0;
      data_q     <= 1'b0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      sfd_q      <= 1'b0;
      len_q      <= 7'd0;
      len_err_q  <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      idle_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
      sfd_q      <= sfd_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      idle_q     <= idle_d;
    end
  end

  assign data_o         = data_q;
  assign valid_o        = valid_q;
  assign frame_active_o = active_q;
  assign sfd_found_o    = sfd_q;
  assign len_o          = len_q;
  assign len_err_o      = len_err_q;
  assign frame_done_o   = done_q;
  assign abort_o        = abort_q;

endmodule

// File: tb/tb_sfd_detector.sv
// Directed bench for sfd_detector; timeout branch follows SFD_DET_TIMEOUT_EN.
module tb_sfd_detector;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_i, data_i, valid_i;
  logic data_o, valid_o, frame_active_o, sfd_found_o, len_err_o, frame_done_o, abort_o;
  logic [6:0] len_o;

  sfd_detector #(.SFD(8'hA7), .PREAMBLE_MIN_BITS(8), .MAX_LEN(127), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .valid_i(valid_i),
    .data_o(data_o), .valid_o(valid_o), .frame_active_o(frame_active_o),
    .sfd_found_o(sfd_found_o), .len_o(len_o), .len_err_o(len_err_o),
    .frame_done_o(frame_done_o), .abort_o(abort_o)
  );

  always #5 clk = ~clk;

  int passes = 0, checks = 0;
  int n_valid = 0, n_sfd = 0, n_lenerr = 0, n_done = 0, n_abort = 0, n_bad_done = 0;
  logic [15:0] rx_sr = 16'h0;

  always @(negedge clk) begin
    if (valid_o) begin
      n_valid++;
      rx_sr = {data_o, rx_sr[15:1]};
    end
    if (sfd_found_o) n_sfd++;
    if (len_err_o) n_lenerr++;
    if (frame_done_o) n_done++;
    if (abort_o) n_abort++;
    if (frame_done_o && !valid_o) n_bad_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_i = b; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; data_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic hdr(input logic [7:0] len);
    send_zeros(8); send_byte(8'hA7); send_byte(len);
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({data_o, valid_o, frame_active_o, sfd_found_o, len_err_o, frame_done_o, abort_o, len_o});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int bv, bs, bd, be, ba, k_hit;
    logic [7:0] pb;
    rst_i = 1'b1; data_i = 1'b0; valid_i = 1'b0;
    #12;
    chk("reset_outs", all_outs(), 0);
    @(negedge clk); rst_i = 1'b0;

    // Nominal frame
    bv = n_valid; bs = n_sfd; bd = n_done;
    send_zeros(8); send_byte(8'hA7);
    chk("sfd_pulse", 32'(sfd_found_o), 1);
    chk("active_on", 32'(frame_active_o), 1);
    send_byte(8'h02);
    chk("len_nominal", 32'(len_o), 2);
    send_byte(8'hC3); send_byte(8'h5A);
    chk("last_valid", 32'(valid_o), 1);
    chk("done_coinc", 32'(frame_done_o), 1);
    chk("active_off", 32'(frame_active_o), 0);
    @(negedge clk); #1;
    chk("nom_valid_cnt", n_valid - bv, 16);
    chk("nom_payload", 32'(rx_sr), 32'h5AC3);
    chk("nom_sfd_cnt", n_sfd - bs, 1);
    chk("nom_done_cnt", n_done - bd, 1);

    // Short preamble, then a proper one leading into PHR 0x00
    bv = n_valid; bs = n_sfd; be = n_lenerr;
    send_zeros(7); send_byte(8'hA7);
    @(negedge clk); #1;
    chk("short_pre_sfd", n_sfd - bs, 0);
    send_zeros(8); send_byte(8'hA7);
    chk("relock_sfd", 32'(sfd_found_o), 1);
    send_byte(8'h00);
    chk("len0_err", 32'(len_err_o), 1);
    chk("len0_inactive", 32'(frame_active_o), 0);
    chk("len0_len_held", 32'(len_o), 2);
    hdr(8'h80);
    chk("len80_err", 32'(len_err_o), 1);
    chk("len80_len_held", 32'(len_o), 2);
    @(negedge clk); #1;
    chk("err_no_valid", n_valid - bv, 0);
    chk("err_cnt", n_lenerr - be, 2);

    // Max-length frame back-to-back with a 1-byte frame, continuous strobes
    bv = n_valid; bd = n_done;
    hdr(8'hFF);
    chk("len_max", 32'(len_o), 127);
    for (int i = 0; i < 127; i++) begin
      pb = 8'(i);
      send_byte(pb);
    end
    chk("max_done", 32'(frame_done_o), 1);
    hdr(8'h01);
    chk("b2b_len", 32'(len_o), 1);
    send_byte(8'h3C);
    chk("b2b_done", 32'(frame_done_o), 1);
    @(negedge clk); #1;
    chk("b2b_valid_cnt", n_valid - bv, 1024);
    chk("b2b_tail", 32'(rx_sr), 32'h3C7E);
    chk("b2b_done_cnt", n_done - bd, 2);
    chk("done_coinc_all", n_bad_done, 0);

    // Reset during payload bit 5
    hdr(8'h02);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bd = n_done;
    @(negedge clk); #2 rst_i = 1'b1;
    #1 chk("reset_mid_outs", all_outs(), 0);
    @(negedge clk); rst_i = 1'b0;
    hdr(8'h01);
    send_byte(8'h96);
    chk("post_rst_done", 32'(frame_done_o), 1);
    chk("post_rst_len", 32'(len_o), 1);
    @(negedge clk); #1;
    chk("post_rst_payload", 32'(rx_sr[15:8]), 32'h96);
    chk("post_rst_done_cnt", n_done - bd, 1);

    // Stall after 3 payload bits
    hdr(8'h02);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ba = n_abort; bd = n_done;
`ifdef SFD_DET_TIMEOUT_EN
    k_hit = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (abort_o && k_hit == 0) k_hit = k;
    end
    chk("abort_cycle", k_hit, TO);
    chk("abort_inactive", 32'(frame_active_o), 0);
    @(negedge clk); #1;
    chk("abort_cnt", n_abort - ba, 1);
    chk("abort_no_done", n_done - bd, 0);
`else
    k_hit = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("stall_active", 32'(frame_active_o), 1);
    @(negedge clk); #1;
    chk("stall_no_abort", n_abort - ba, k_hit);
    chk("stall_no_done", n_done - bd, 0);
`endif
    @(negedge clk); rst_i = 1'b1;
    @(negedge clk); rst_i = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/sfd_detector.md
# sfd_detector

Receive-path framing stage between the CDR and the Rx FIFO. It consumes the recovered bit stream (CDR data/valid strobe) and hunts for an IEEE 802.15.4 preamble followed by the start-of-frame delimiter. It then captures the PHR length byte and forwards exactly the announced number of PSDU bits to the Rx FIFO's data/valid inputs. It also reports frame start, end, length errors and aborts to the platform.

## Interface
- `SFD`, default 8'hA7, delimiter byte, received LSB first; bit 0 must be 1.
- `PREAMBLE_MIN_BITS`, default 8, minimum run of consecutive zero bits that must precede the SFD; range 1..255.
- `MAX_LEN`, default 127, maximum accepted PSDU length in bytes; range 1..127.
- `TIMEOUT_CYCLES`, default 1024, idle-clock limit inside a frame (only with `SFD_DET_TIMEOUT_EN`).

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: asynchronous, active-high reset.
- `data_i` in 1: recovered bit from the CDR.
- `valid_i` in 1: single-cycle bit strobe; every cycle it is high carries one bit.
- `data_o` in direction out, 1: forwarded PSDU bit, to the Rx FIFO.
- `valid_o` out 1: forwarded-bit strobe.
- `frame_active_o` out 1: high from SFD match until the frame ends or is dropped.
- `sfd_found_o` out 1: one-cycle pulse on SFD match.
- `len_o` out 7: last accepted PHR length; held until the next accepted PHR.
- `len_err_o` out 1: one-cycle pulse when the PHR is rejected.
- `frame_done_o` out 1: one-cycle pulse, coincident with the last `valid_o`.
- `abort_o` out 1: one-cycle pulse on timeout.

## Operation
- **Bit order:** every byte is assembled LSB first. The shift register shifts right, and each new bit enters bit 7.
- **HUNT_PRE:**
  - A 0 bit increments `zero_cnt` (8-bit, saturating at 255).
  - A 1 bit with `zero_cnt >= PREAMBLE_MIN_BITS` loads the shift register with that bit, sets bit count to 1, and goes to HUNT_SFD.
  - A 1 bit otherwise clears `zero_cnt`.
- **HUNT_SFD:**
  - Collect until 8 bits are held, then compare the register with `SFD`.
  - Match: pulse `sfd_found_o`, set `frame_active_o`, go to LEN.
  - Mismatch: clear `zero_cnt`, go to HUNT_PRE. No re-scan of the buffered bits.
- **LEN:**
  - Collect 8 bits; the length is bits [6:0], and bit 7 is reserved and ignored.
  - Length 0 or greater than `MAX_LEN`: pulse `len_err_o`, clear `frame_active_o`, clear `zero_cnt`, go to HUNT_PRE. `len_o` is unchanged.
  - Otherwise: update `len_o`, load the 10-bit `remaining` counter with length×8, go to PAYLOAD.
- **PAYLOAD:**
  - On each `valid_i`, register `data_i` to `data_o`, pulse `valid_o`, and decrement `remaining`.
  - On the bit that takes `remaining` to 0, also pulse `frame_done_o`.
  - The FSM then returns to HUNT_PRE and `frame_active_o` drops with `zero_cnt` cleared. Both take effect on the same edge that issues that last bit.
- **Input gating:** `data_i` is ignored whenever `valid_i` is low. PHR bits are never forwarded, and `valid_o` is never asserted outside PAYLOAD.
- **Back-to-back frames:** a new frame requires a fresh preamble of at least `PREAMBLE_MIN_BITS` zeros after `frame_done_o`.

## Timing
- **Reset:** all outputs are 0 (including `len_o`), the state is HUNT_PRE, and all counters and the shift register are cleared. Reset asserted mid-frame drops the frame immediately, with no `frame_done_o` or `abort_o`.
- **Latency:** one clock.
  - `valid_o`/`data_o` follow the accepting `valid_i` by exactly one clock.
  - `sfd_found_o` and `len_err_o` are registered one clock after the 8th bit's strobe.
  - `len_o` takes its new value on the same edge.
- **Throughput:** the block accepts a bit on every cycle; consecutive-cycle `valid_i` is legal and yields consecutive-cycle `valid_o`.
- **No backpressure:** the downstream Rx FIFO must absorb one bit per `valid_o`.
- **Output pulse width:** every pulse output is exactly one cycle wide.

## Configuration
- Macro `SFD_DET_TIMEOUT_EN`.
- **Defined:**
  - A 16-bit idle counter runs in HUNT_SFD, LEN and PAYLOAD.
  - It clears on every `valid_i` and on every state entry.
  - When it reaches `TIMEOUT_CYCLES` with no strobe: pulse `abort_o`, clear `frame_active_o` and `zero_cnt`, go to HUNT_PRE. No `frame_done_o` is issued.
  - If `valid_i` arrives in the same cycle the limit is reached, the bit wins and the counter clears.
- **Undefined:**
  - No counter is built, `abort_o` is tied to 0, and a stalled frame waits indefinitely.

## Test plan
- **Nominal frame:** 8 zeros, then 0xA7 LSB first, then PHR 0x02, then 16 payload bits 0xC3,0x5A. Required response:
  - `sfd_found_o` pulses once.
  - `len_o` = 2.
  - 16 `valid_o` pulses with `data_o` reproducing the payload bits in order.
  - `frame_done_o` coincident with the 16th `valid_o`.
  - `frame_active_o` then low.
- **Short preamble:** 7 zeros, then 0xA7. Required response: no `sfd_found_o` and no `valid_o`. The same stream repeated with 8 zeros then locks.
- **Length errors:**
  - PHR 0x00 → `len_err_o` pulse and no `valid_o`.
  - PHR 0x80 → reserved bit ignored, length 0, so `len_err_o`.
  - PHR 0xFF with `MAX_LEN` = 127 → accepted, 1016 payload bits forwarded.
- **Back-to-back frames:** consecutive-cycle `valid_i` with two frames separated by 8 zeros → both delivered, and the `valid_o` count equals the sum of the lengths × 8.
- **Reset mid-frame:** assert `rst_i` for 1 cycle during PAYLOAD bit 5 of a 2-byte frame → all outputs read 0 immediately and no `frame_done_o`. The next valid frame is received correctly.
- **Timeout (with `SFD_DET_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 20):**
  - Stop `valid_i` after 3 payload bits → `abort_o` exactly 20 cycles after the last strobe, state HUNT_PRE.
  - Without the macro, the same stimulus yields no `abort_o` and `frame_active_o` stays high.
